sr_bank_register: RTL

//  Segment/bank register (SR) holding the upper address bits for banked register access.

---
 rtl/sr_bank_register.sv | 99 +++++++++
 1 files changed

// File: rtl/sr_bank_register.sv
// Segment/bank register supplying the upper address bits for banked operands,
// with load/inc/dec and a LIFO save stack for call/interrupt entry and exit.
module sr_bank_register #(
  parameter int                 SR_W        = 4,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [SR_W-1:0]    RESET_VAL   = '0
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            sr_wr_en,
  input  logic [SR_W-1:0] sr_wr_data,
  input  logic            sr_inc,
  input  logic            sr_dec,
  input  logic            push,
  input  logic            pop,
  input  logic            err_clr,
  output logic [SR_W-1:0] sr_value,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic [SR_W-1:0]  stack_mem [STACK_DEPTH];

  logic             do_push;
  logic             do_pop;
  logic             err_event;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  function automatic logic [SR_W-1:0] sr_wrap_inc(input logic [SR_W-1:0] v);
    return v + SR_W'(1);
  endfunction

  function automatic logic [SR_W-1:0] sr_wrap_dec(input logic [SR_W-1:0] v);
    return v - SR_W'(1);
  endfunction

  assign stack_full  = (count_q == DEPTH_C);
  assign stack_empty = (count_q == '0);

  // A simultaneous push and pop is treated as illegal and leaves the stack alone.
  always_comb begin
    do_push   = push & ~pop & ~stack_full;
    do_pop    = pop & ~push & ~stack_empty;
    err_event = (push & pop) | (push & ~pop & stack_full) | (pop & ~push & stack_empty);
    wr_idx    = IDX_W'(count_q);
    top_idx   = IDX_W'(count_q - CNT_W'(1));
  end

  // A successful restore beats any same-cycle load/inc/dec of the SR.
  always_comb begin
    sr_next = sr_q;
    if (do_pop)
      sr_next = stack_mem[top_idx];
    else if (sr_wr_en)
      sr_next = sr_wr_data;
    else if (sr_inc && !sr_dec)
      sr_next = sr_wrap_inc(sr_q);
    else if (sr_dec && !sr_inc)
      sr_next = sr_wrap_dec(sr_q);
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      sr_q    <= RESET_VAL;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sr_q <= sr_next;
      if (do_push)
        count_q <= count_q + CNT_W'(1);
      else if (do_pop)
        count_q <= count_q - CNT_W'(1);
      if (err_event)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

  // Stack storage holds the pre-update SR; contents need no reset.
  always_ff @(posedge clk) begin
    if (res_n && do_push)
      stack_mem[wr_idx] <= sr_q;
  end

  assign sr_value  = sr_q;
  assign stack_err = err_q;

endmodule
